// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - decode stage types and constants; DECODE_MUL_EN adds the M-extension codes
package decode_pkg;

   // ALU operation codes handed to the execute stage
   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_SLL    = 5'd2,
      ALU_SLT    = 5'd3,
      ALU_SLTU   = 5'd4,
      ALU_XOR    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_OR     = 5'd8,
      ALU_AND    = 5'd9,
      ALU_MUL    = 5'd16,
      ALU_MULH   = 5'd17,
      ALU_MULHSU = 5'd18,
      ALU_MULHU  = 5'd19,
      ALU_DIV    = 5'd20,
      ALU_DIVU   = 5'd21,
      ALU_REM    = 5'd22,
      ALU_REMU   = 5'd23
   } alu_op_t;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;

   localparam logic [6:0] F7_ZERO   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational opcode/funct to ALU op map; DECODE_MUL_EN enables MUL/DIV
module alu_op_decode
   import decode_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [4:0] alu_op,
   output logic       use_imm,
   output logic       illegal
);

   alu_op_t op;
   logic    imm_sel;
   logic    ill;

   // Map the instruction fields to an operation; anything unmatched stays illegal
   always_comb begin
      op      = ALU_ADD;
      imm_sel = 1'b0;
      ill     = 1'b1;
      if (opcode == OP_R) begin
         if (funct7 == F7_ZERO) begin
            ill = 1'b0;
            case (funct3)
               3'b000:  op = ALU_ADD;
               3'b001:  op = ALU_SLL;
               3'b010:  op = ALU_SLT;
               3'b011:  op = ALU_SLTU;
               3'b100:  op = ALU_XOR;
               3'b101:  op = ALU_SRL;
               3'b110:  op = ALU_OR;
               default: op = ALU_AND;
            endcase
         end else if (funct7 == F7_ALT) begin
            if (funct3 == 3'b000) begin
               op  = ALU_SUB;
               ill = 1'b0;
            end else if (funct3 == 3'b101) begin
               op  = ALU_SRA;
               ill = 1'b0;
            end
         end
`ifdef DECODE_MUL_EN
         else if (funct7 == F7_MULDIV) begin
            ill = 1'b0;
            op  = alu_op_t'({2'b10, funct3});
         end
`endif
      end else if (opcode == OP_I) begin
         imm_sel = 1'b1;
         case (funct3)
            3'b000: begin op = ALU_ADD;  ill = 1'b0; end
            3'b010: begin op = ALU_SLT;  ill = 1'b0; end
            3'b011: begin op = ALU_SLTU; ill = 1'b0; end
            3'b100: begin op = ALU_XOR;  ill = 1'b0; end
            3'b110: begin op = ALU_OR;   ill = 1'b0; end
            3'b111: begin op = ALU_AND;  ill = 1'b0; end
            3'b001: begin
               if (funct7 == F7_ZERO) begin
                  op  = ALU_SLL;
                  ill = 1'b0;
               end
            end
            default: begin
               if (funct7 == F7_ZERO) begin
                  op  = ALU_SRL;
                  ill = 1'b0;
               end else if (funct7 == F7_ALT) begin
                  op  = ALU_SRA;
                  ill = 1'b0;
               end
            end
         endcase
      end
      // illegal encodings present a neutral operation with no immediate
      if (ill) begin
         op      = ALU_ADD;
         imm_sel = 1'b0;
      end
   end

   assign alu_op  = op;
   assign use_imm = imm_sel;
   assign illegal = ill;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I ALU decode stage with counters; DECODE_MUL_EN enables M-extension decode
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic [4:0]       alu_op,
   output logic [XLEN-1:0]  imm,
   output logic             use_imm,
   output logic             rd_we,
   output logic             illegal,
   output logic [CNT_W-1:0] dec_cnt,
   output logic [CNT_W-1:0] ill_cnt
);

   logic [4:0]      alu_op_d;
   logic            use_imm_d;
   logic            illegal_d;
   logic [XLEN-1:0] imm_d;
   logic [4:0]      rs2_d;
   logic            rd_we_d;
   logic            accept;
   logic            depart;

   alu_op_decode u_alu_op_decode (
      .opcode  (instr[6:0]),
      .funct3  (instr[14:12]),
      .funct7  (instr[31:25]),
      .alu_op  (alu_op_d),
      .use_imm (use_imm_d),
      .illegal (illegal_d)
   );

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   assign depart   = out_valid && out_ready;

   // Next payload fields: immediate only for legal I-type, rs2 zeroed when the immediate replaces it
   always_comb begin
      imm_d   = '0;
      rs2_d   = instr[24:20];
      rd_we_d = !illegal_d && (instr[11:7] != 5'd0);
      if (use_imm_d) begin
         imm_d = {{(XLEN-12){instr[31]}}, instr[31:20]};
         rs2_d = 5'd0;
      end
   end

   // Handshake, payload registers and statistics counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         rs1       <= '0;
         rs2       <= '0;
         rd        <= '0;
         alu_op    <= '0;
         imm       <= '0;
         use_imm   <= 1'b0;
         rd_we     <= 1'b0;
         illegal   <= 1'b0;
         dec_cnt   <= '0;
         ill_cnt   <= '0;
      end else begin
         if (depart) begin
            dec_cnt <= dec_cnt + 1'b1;
            if (illegal) begin
               ill_cnt <= ill_cnt + 1'b1;
            end
         end
         if (flush) begin
            out_valid <= 1'b0;
         end else if (accept) begin
            out_valid <= 1'b1;
            rs1       <= instr[19:15];
            rs2       <= rs2_d;
            rd        <= instr[11:7];
            alu_op    <= alu_op_d;
            imm       <= imm_d;
            use_imm   <= use_imm_d;
            rd_we     <= rd_we_d;
            illegal   <= illegal_d;
         end else if (depart) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed bench for decode_stage (CNT_W = 4); honours DECODE_MUL_EN
module tb_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  rs1, rs2, rd, alu_op;
   logic [31:0] imm;
   logic        use_imm, rd_we, illegal;
   logic [3:0]  dec_cnt, ill_cnt;

   int n_assert = 0;
   int n_fail   = 0;

`ifdef DECODE_MUL_EN
   localparam logic [4:0] MUL_OP  = 5'd16;
   localparam logic       MUL_ILL = 1'b0;
`else
   localparam logic [4:0] MUL_OP  = 5'd0;
   localparam logic       MUL_ILL = 1'b1;
`endif

   decode_stage #(.XLEN(32), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rs1       (rs1),
      .rs2       (rs2),
      .rd        (rd),
      .alu_op    (alu_op),
      .imm       (imm),
      .use_imm   (use_imm),
      .rd_we     (rd_we),
      .illegal   (illegal),
      .dec_cnt   (dec_cnt),
      .ill_cnt   (ill_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] edec;
      logic [3:0] eill;

      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      instr     = 32'd0;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_dec_cnt", {28'd0, dec_cnt}, 32'd0);
      chk("rst_ill_cnt", {28'd0, ill_cnt}, 32'd0);
      chk("rst_imm", imm, 32'd0);
      chk("rst_rs1", {27'd0, rs1}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;

      // add x3,x1,x2 with execute stalled
      @(negedge clk);
      in_valid = 1'b1; instr = 32'h002081B3;
      @(negedge clk);
      in_valid = 1'b0;
      chk("add_valid", {31'd0, out_valid}, 32'd1);
      chk("add_rs1", {27'd0, rs1}, 32'd1);
      chk("add_rs2", {27'd0, rs2}, 32'd2);
      chk("add_rd", {27'd0, rd}, 32'd3);
      chk("add_op", {27'd0, alu_op}, 32'd0);
      chk("add_rd_we", {31'd0, rd_we}, 32'd1);
      chk("add_use_imm", {31'd0, use_imm}, 32'd0);
      chk("add_imm", imm, 32'd0);
      chk("add_illegal", {31'd0, illegal}, 32'd0);
      chk("add_in_ready_stall", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      #1;
      chk("add_in_ready_go", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      chk("add_gone", {31'd0, out_valid}, 32'd0);
      chk("add_dec_cnt", {28'd0, dec_cnt}, 32'd1);
      edec = 4'd1;
      eill = 4'd0;

      // back-to-back: sub, addi, mul, zero word, srai, bad slli
      in_valid = 1'b1; instr = 32'h402081B3;
      @(negedge clk);
      chk("sub_op", {27'd0, alu_op}, 32'd1);
      chk("sub_valid", {31'd0, out_valid}, 32'd1);
      instr = 32'hFFF00293;
      @(negedge clk);
      edec = edec + 4'd1;
      chk("addi_imm", imm, 32'hFFFFFFFF);
      chk("addi_use_imm", {31'd0, use_imm}, 32'd1);
      chk("addi_rd", {27'd0, rd}, 32'd5);
      chk("addi_rs2", {27'd0, rs2}, 32'd0);
      chk("addi_rs1", {27'd0, rs1}, 32'd0);
      chk("addi_op", {27'd0, alu_op}, 32'd0);
      chk("addi_rd_we", {31'd0, rd_we}, 32'd1);
      chk("addi_dec_cnt", {28'd0, dec_cnt}, {28'd0, edec});
      instr = 32'h022081B3;
      @(negedge clk);
      edec = edec + 4'd1;
      chk("mul_op", {27'd0, alu_op}, {27'd0, MUL_OP});
      chk("mul_illegal", {31'd0, illegal}, {31'd0, MUL_ILL});
      chk("mul_rd_we", {31'd0, rd_we}, {31'd0, ~MUL_ILL});
      chk("mul_rs2", {27'd0, rs2}, 32'd2);
      instr = 32'h00000000;
      @(negedge clk);
      edec = edec + 4'd1;
      if (MUL_ILL) eill = eill + 4'd1;
      chk("zero_illegal", {31'd0, illegal}, 32'd1);
      chk("zero_op", {27'd0, alu_op}, 32'd0);
      chk("zero_use_imm", {31'd0, use_imm}, 32'd0);
      chk("zero_rd_we", {31'd0, rd_we}, 32'd0);
      chk("zero_imm", imm, 32'd0);
      chk("mul_ill_cnt", {28'd0, ill_cnt}, {28'd0, eill});
      instr = 32'h4050D093;
      @(negedge clk);
      edec = edec + 4'd1;
      eill = eill + 4'd1;
      chk("srai_op", {27'd0, alu_op}, 32'd7);
      chk("srai_imm", imm, 32'h00000405);
      chk("srai_use_imm", {31'd0, use_imm}, 32'd1);
      chk("srai_rs1", {27'd0, rs1}, 32'd1);
      chk("srai_rs2", {27'd0, rs2}, 32'd0);
      chk("zero_ill_cnt", {28'd0, ill_cnt}, {28'd0, eill});
      instr = 32'h40009093;
      @(negedge clk);
      edec = edec + 4'd1;
      in_valid = 1'b0;
      chk("slli_bad_illegal", {31'd0, illegal}, 32'd1);
      chk("slli_bad_imm", imm, 32'd0);
      chk("slli_bad_use_imm", {31'd0, use_imm}, 32'd0);
      chk("slli_bad_rd", {27'd0, rd}, 32'd1);
      @(negedge clk);
      edec = edec + 4'd1;
      eill = eill + 4'd1;
      chk("burst_done_valid", {31'd0, out_valid}, 32'd0);
      chk("burst_dec_cnt", {28'd0, dec_cnt}, {28'd0, edec});
      chk("burst_ill_cnt", {28'd0, ill_cnt}, {28'd0, eill});

      // stall three cycles with a new instruction waiting, then release
      in_valid = 1'b1; instr = 32'h00A4A433;
      @(negedge clk);
      out_ready = 1'b0; instr = 32'h00A4B433;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_op", {27'd0, alu_op}, 32'd3);
         chk("stall_rd", {27'd0, rd}, 32'd8);
         chk("stall_rs2", {27'd0, rs2}, 32'd10);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         chk("stall_dec_cnt", {28'd0, dec_cnt}, {28'd0, edec});
      end
      out_ready = 1'b1;
      @(negedge clk);
      edec = edec + 4'd1;
      chk("rel_sltu_op", {27'd0, alu_op}, 32'd4);
      chk("rel_sltu_valid", {31'd0, out_valid}, 32'd1);
      chk("rel_dec1", {28'd0, dec_cnt}, {28'd0, edec});
      instr = 32'h00A4C433;
      @(negedge clk);
      edec = edec + 4'd1;
      in_valid = 1'b0;
      chk("rel_xor_op", {27'd0, alu_op}, 32'd5);
      chk("rel_dec2", {28'd0, dec_cnt}, {28'd0, edec});
      @(negedge clk);
      edec = edec + 4'd1;
      chk("rel_drained", {31'd0, out_valid}, 32'd0);
      chk("rel_dec3", {28'd0, dec_cnt}, {28'd0, edec});

      // flush while holding, incoming dropped, no count
      in_valid = 1'b1; instr = 32'h002081B3; out_ready = 1'b0;
      @(negedge clk);
      flush = 1'b1; instr = 32'h402081B3;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_dec_cnt", {28'd0, dec_cnt}, {28'd0, edec});
      chk("flush_ill_cnt", {28'd0, ill_cnt}, {28'd0, eill});
      @(negedge clk);
      chk("flush_stays_idle", {31'd0, out_valid}, 32'd0);

      // flush coinciding with a handshake still counts it
      in_valid = 1'b1; instr = 32'h00000000;
      @(negedge clk);
      out_ready = 1'b1; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      edec = edec + 4'd1;
      eill = eill + 4'd1;
      chk("flush_hs_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_hs_dec", {28'd0, dec_cnt}, {28'd0, edec});
      chk("flush_hs_ill", {28'd0, ill_cnt}, {28'd0, eill});

      // reset while an illegal instruction is held: discarded, nothing counted
      in_valid = 1'b1; instr = 32'h00000000; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_illegal", {31'd0, illegal}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      chk("rst_mid_dec", {28'd0, dec_cnt}, 32'd0);
      chk("rst_mid_ill", {28'd0, ill_cnt}, 32'd0);

      // 16 back-to-back handshakes wrap the 4-bit counter to 0
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         in_valid = 1'b1; instr = 32'h00100093;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("wrap_dec_15", {28'd0, dec_cnt}, 32'd15);
      chk("wrap_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      chk("wrap_dec_0", {28'd0, dec_cnt}, 32'd0);
      chk("wrap_ill_0", {28'd0, ill_cnt}, 32'd0);
      chk("wrap_idle", {31'd0, out_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
